srl_fifo_ctrl: RTL and testbench
================================

SRL_FIFO_CTRL -- requirements
Module: srl_fifo_ctrl

Interface
REQ-001 SHALL have parameter SELWIDTH, default 5, meaning log2 of FIFO depth; DEPTH = 2**SELWIDTH entries.
REQ-002 SHALL have parameter WIDTH, default 8, meaning data bits per entry.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RSTN  input  1  the reset; asynchronous, active-low.
REQ-005 SHALL have port IN_VALID  input  1  write request.
REQ-006 SHALL have port IN_READY  output  1  FIFO can accept a write.
REQ-007 SHALL have port IN_DATA  input  WIDTH  write data.
REQ-008 SHALL have port OUT_VALID  output  1  head entry available.
REQ-009 SHALL have port OUT_READY  input  1  consumer takes head.
REQ-010 SHALL have port OUT_DATA  output  WIDTH  head entry (oldest).

Function
REQ-011 SHALL store data in a WIDTH-wide dynamic shift register of DEPTH stages; a push shifts every stage up one position and loads IN_DATA into stage 0.
REQ-012 SHALL keep an occupancy counter COUNT of SELWIDTH+1 bits, range 0..DEPTH.
REQ-013 SHALL read OUT_DATA combinationally from stage COUNT-1 (SEL = COUNT-1, truncated to SELWIDTH bits); OUT_DATA is don't-care when COUNT = 0.
REQ-014 SHALL define push = IN_VALID & IN_READY and pop = OUT_VALID & OUT_READY.
REQ-015 SHALL keep three states: EMPTY (COUNT=0), ACTIVE (0<COUNT<DEPTH), FULL (COUNT=DEPTH); the state is held in registers, not decoded from COUNT.
REQ-016 SHALL update on push only: COUNT+1; EMPTY->ACTIVE, or ACTIVE->FULL when COUNT becomes DEPTH.
REQ-017 SHALL update on pop only: COUNT-1; FULL->ACTIVE, or ACTIVE->EMPTY when COUNT becomes 0.
REQ-018 SHALL hold COUNT and state on simultaneous push and pop; the shift alone advances the head to the next-oldest entry.
REQ-019 SHALL drive IN_READY = (state != FULL) and OUT_VALID = (state != EMPTY), both straight from registers with no combinational path from OUT_READY or IN_VALID.
REQ-020 SHALL ignore IN_VALID while FULL (no shift, no count change) and OUT_READY while EMPTY.
REQ-021 SHALL give one-cycle write-to-read latency: data pushed into an empty FIFO appears with OUT_VALID high on the next cycle.

Reset
REQ-022 SHALL, on RSTN low, force COUNT=0, state=EMPTY, OUT_VALID=0 and IN_READY=1 immediately, asynchronously to CLK.
REQ-023 SHALL not reset the shift-register stages (SRL-inferable); contents after reset are stale and never presented as valid.
REQ-024 SHALL discard all stored entries on reset mid-operation; the first push after RSTN rises is the next head.

Configuration
REQ-025 SHALL, when SRL_FIFO_CTRL_LEVEL_EN is defined, add output LEVEL (SELWIDTH+1 bits, equal to COUNT) and output ALMOST_FULL (1 bit, registered, high when COUNT >= DEPTH-2 after the update); both reset to 0.
REQ-026 SHALL, without SRL_FIFO_CTRL_LEVEL_EN, omit LEVEL and ALMOST_FULL; all other behaviour is identical.

Structure
REQ-027 SHALL place the state enumeration typedef (EMPTY, ACTIVE, FULL) and the default SELWIDTH/WIDTH constants in shared package srl_fifo_pkg.
REQ-028 SHALL implement the storage as one sub-module, srl_shift_data (ports CLK, CE, SEL, SI[WIDTH], DO[WIDTH]), a WIDTH-wide dynamic shift register with no reset; srl_fifo_ctrl drives CE=push and SEL=COUNT-1.

Verification
REQ-029 SHALL cover reset: RSTN low mid-stream with COUNT=5 -> OUT_VALID=0, IN_READY=1 and COUNT=0 without waiting for a CLK edge.
REQ-030 SHALL cover ordering: push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 -> OUT_DATA reads 0x11, 0x22, 0x33, then OUT_VALID=0.
REQ-031 SHALL cover fill (SELWIDTH=5): 32 pushes -> IN_READY=0; a 33rd IN_VALID is dropped; popping 32 returns entries 0..31 in order.
REQ-032 SHALL cover simultaneous push and pop at COUNT=4 -> COUNT stays 4 and the head advances to the second-oldest entry.
REQ-033 SHALL cover simultaneous push and pop when EMPTY -> only the push takes effect, so COUNT=1 and the pop is ignored; when FULL -> only the pop takes effect, so COUNT=31.
REQ-034 SHALL cover SRL_FIFO_CTRL_LEVEL_EN defined: ALMOST_FULL rises after the 30th push, and LEVEL tracks COUNT on every cycle.

Source files
------------

// File: rtl/srl_fifo_pkg.sv
// Shared types and default sizing for the SRL-based FIFO controller.
package srl_fifo_pkg;

  localparam int unsigned DEF_SELWIDTH = 5;
  localparam int unsigned DEF_WIDTH    = 8;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_t;

endpackage

// File: rtl/srl_shift_data.sv
// WIDTH-wide dynamic shift register of 2**SELWIDTH stages, no reset (SRL-inferable).
module srl_shift_data
  import srl_fifo_pkg::*;
#(
  parameter int unsigned SELWIDTH = DEF_SELWIDTH,
  parameter int unsigned WIDTH    = DEF_WIDTH
) (
  input  logic                CLK,
  input  logic                CE,
  input  logic [SELWIDTH-1:0] SEL,
  input  logic [WIDTH-1:0]    SI,
  output logic [WIDTH-1:0]    DO
);

  localparam int unsigned DEPTH = 1 << SELWIDTH;

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge CLK) begin
    if (CE) begin
      for (int unsigned i = DEPTH - 1; i > 0; i--) begin
        sr[i] <= sr[i-1];
      end
      sr[0] <= SI;
    end
  end

  assign DO = sr[SEL];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// FIFO controller around an SRL data store; head is read from stage COUNT-1.
// Optional LEVEL / ALMOST_FULL outputs are enabled by defining SRL_FIFO_CTRL_LEVEL_EN.
module srl_fifo_ctrl
  import srl_fifo_pkg::*;
#(
  parameter int unsigned SELWIDTH = DEF_SELWIDTH,
  parameter int unsigned WIDTH    = DEF_WIDTH
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [WIDTH-1:0]    IN_DATA,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [WIDTH-1:0]    OUT_DATA
`ifdef SRL_FIFO_CTRL_LEVEL_EN
  ,
  output logic [SELWIDTH:0]   LEVEL,
  output logic                ALMOST_FULL
`endif
);

  localparam logic [SELWIDTH:0]   DEPTH_C = (SELWIDTH+1)'(1 << SELWIDTH);
  localparam logic [SELWIDTH:0]   CNT_ONE = (SELWIDTH+1)'(1);
  localparam logic [SELWIDTH-1:0] SEL_ONE = SELWIDTH'(1);

  state_t              state, state_nxt;
  logic [SELWIDTH:0]   count, count_nxt;
  logic [SELWIDTH-1:0] sel;
  logic                push, pop;

  assign IN_READY  = (state != FULL);
  assign OUT_VALID = (state != EMPTY);
  assign push      = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;

  // Truncation wraps to the top stage when empty; OUT_DATA is don't-care then.
  assign sel = count[SELWIDTH-1:0] - SEL_ONE;

  always_comb begin
    count_nxt = count;
    state_nxt = state;
    if (push && !pop) begin
      count_nxt = count + CNT_ONE;
      state_nxt = (count_nxt == DEPTH_C) ? FULL : ACTIVE;
    end else if (pop && !push) begin
      count_nxt = count - CNT_ONE;
      state_nxt = (count_nxt == '0) ? EMPTY : ACTIVE;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count <= '0;
      state <= EMPTY;
    end else begin
      count <= count_nxt;
      state <= state_nxt;
    end
  end

  srl_shift_data #(
    .SELWIDTH (SELWIDTH),
    .WIDTH    (WIDTH)
  ) u_data (
    .CLK (CLK),
    .CE  (push),
    .SEL (sel),
    .SI  (IN_DATA),
    .DO  (OUT_DATA)
  );

`ifdef SRL_FIFO_CTRL_LEVEL_EN
  localparam logic [SELWIDTH:0] AF_TH = DEPTH_C - (SELWIDTH+1)'(2);

  assign LEVEL = count;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ALMOST_FULL <= 1'b0;
    end else begin
      ALMOST_FULL <= (count_nxt >= AF_TH);
    end
  end
`endif

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Self-checking bench for srl_fifo_ctrl against a queue-based FIFO model.
module tb_srl_fifo_ctrl;
  import srl_fifo_pkg::*;

  localparam int unsigned SELWIDTH = 5;
  localparam int unsigned WIDTH    = 8;
  localparam int unsigned DEPTH    = 1 << SELWIDTH;

  logic             CLK = 1'b0;
  logic             RSTN;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_DATA;
`ifdef SRL_FIFO_CTRL_LEVEL_EN
  logic [SELWIDTH:0] LEVEL;
  logic              ALMOST_FULL;
`endif

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] q[$];

  always #5 CLK = ~CLK;

  srl_fifo_ctrl #(.SELWIDTH(SELWIDTH), .WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA)
`ifdef SRL_FIFO_CTRL_LEVEL_EN
    ,
    .LEVEL       (LEVEL),
    .ALMOST_FULL (ALMOST_FULL)
`endif
  );

  // One clock of stimulus; the model applies the FIFO rules from pre-edge occupancy.
  task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    bit do_push, do_pop;
    IN_VALID  = iv;
    IN_DATA   = d;
    OUT_READY = ordy;
    do_push = iv && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() > 0);
    @(posedge CLK);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(d);
    #1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    q.delete();
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    IN_VALID = 1'b0; OUT_READY = 1'b0; IN_DATA = '0;
    RSTN = 1'b0;
    #3;
    tests++;
    if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
    tests++;
    if (IN_READY !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", IN_READY); end
    tests++;
    if (dut.count !== '0) begin fails++; $display("FAIL reset_count: got %0d expected 0", dut.count); end
    do_reset();
  endtask

  task automatic test_ordering();
    logic [WIDTH-1:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    for (int i = 0; i < 3; i++) drive(1'b1, exp[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== exp[i]) begin
        fails++;
        $display("FAIL order_%0d: got valid=%b data=%h expected valid=1 data=%h", i, OUT_VALID, OUT_DATA, exp[i]);
      end
      drive(1'b0, '0, 1'b1);
    end
    tests++;
    if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL order_drained: got valid=%b expected 0", OUT_VALID); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0) begin
        tests++;
        if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL fill_start_empty: got %b expected 0", OUT_VALID); end
      end
      drive(1'b1, WIDTH'(i), 1'b0);
      if (i == 0) begin
        tests++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h00) begin
          fails++;
          $display("FAIL first_write_latency: got valid=%b data=%h expected valid=1 data=00", OUT_VALID, OUT_DATA);
        end
      end
`ifdef SRL_FIFO_CTRL_LEVEL_EN
      tests++;
      if (LEVEL !== (SELWIDTH+1)'(i + 1)) begin fails++; $display("FAIL fill_level: got %0d expected %0d", LEVEL, i + 1); end
      tests++;
      if (ALMOST_FULL !== ((i + 1) >= 30)) begin
        fails++;
        $display("FAIL almost_full_after_%0d: got %b expected %b", i + 1, ALMOST_FULL, ((i + 1) >= 30));
      end
`endif
    end
    tests++;
    if (IN_READY !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b expected 0", IN_READY); end
    drive(1'b1, 8'hAA, 1'b0);
    tests++;
    if (dut.count !== (SELWIDTH+1)'(DEPTH)) begin fails++; $display("FAIL full_drop_count: got %0d expected %0d", dut.count, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      tests++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== WIDTH'(i)) begin
        fails++;
        $display("FAIL drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, OUT_VALID, OUT_DATA, WIDTH'(i));
      end
      drive(1'b0, '0, 1'b1);
    end
    tests++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      fails++;
      $display("FAIL drain_empty: got valid=%b ready=%b expected valid=0 ready=1", OUT_VALID, IN_READY);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) drive(1'b1, WIDTH'(8'hA0 + i), 1'b0);
    drive(1'b1, 8'hB0, 1'b1);
    tests++;
    if (dut.count !== (SELWIDTH+1)'(4)) begin fails++; $display("FAIL simul_count: got %0d expected 4", dut.count); end
    tests++;
    if (OUT_DATA !== 8'hA1) begin fails++; $display("FAIL simul_head: got %h expected a1", OUT_DATA); end
    do_reset();
    drive(1'b1, 8'h5C, 1'b1);
    tests++;
    if (dut.count !== (SELWIDTH+1)'(1) || OUT_DATA !== 8'h5C) begin
      fails++;
      $display("FAIL simul_empty: got count=%0d data=%h expected count=1 data=5c", dut.count, OUT_DATA);
    end
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, WIDTH'(8'h40 + i), 1'b0);
    drive(1'b1, 8'hEE, 1'b1);
    tests++;
    if (dut.count !== (SELWIDTH+1)'(DEPTH - 1) || OUT_DATA !== 8'h41) begin
      fails++;
      $display("FAIL simul_full: got count=%0d data=%h expected count=%0d data=41", dut.count, OUT_DATA, DEPTH - 1);
    end
    do_reset();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) drive(1'b1, WIDTH'(8'h70 + i), 1'b0);
    #2;
    RSTN = 1'b0;
    q.delete();
    #1;
    tests++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || dut.count !== '0) begin
      fails++;
      $display("FAIL async_reset: got valid=%b ready=%b count=%0d expected valid=0 ready=1 count=0", OUT_VALID, IN_READY, dut.count);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
    drive(1'b1, 8'h5A, 1'b0);
    tests++;
    if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h5A) begin
      fails++;
      $display("FAIL post_reset_head: got valid=%b data=%h expected valid=1 data=5a", OUT_VALID, OUT_DATA);
    end
    do_reset();
  endtask

  task automatic test_random();
    int unsigned push_pct;
    for (int c = 0; c < 1500; c++) begin
      push_pct = ((c / 100) % 2 == 0) ? 80 : 25;
      tests++;
      if (OUT_VALID !== (q.size() != 0) || IN_READY !== (q.size() != DEPTH)) begin
        fails++;
        $display("FAIL rand_flags_c%0d: got valid=%b ready=%b expected valid=%b ready=%b",
                 c, OUT_VALID, IN_READY, (q.size() != 0), (q.size() != DEPTH));
      end
      if (q.size() != 0) begin
        tests++;
        if (OUT_DATA !== q[0]) begin fails++; $display("FAIL rand_data_c%0d: got %h expected %h", c, OUT_DATA, q[0]); end
      end
`ifdef SRL_FIFO_CTRL_LEVEL_EN
      tests++;
      if (LEVEL !== (SELWIDTH+1)'(q.size()) || ALMOST_FULL !== (q.size() >= DEPTH - 2)) begin
        fails++;
        $display("FAIL rand_level_c%0d: got level=%0d af=%b expected level=%0d af=%b",
                 c, LEVEL, ALMOST_FULL, q.size(), (q.size() >= DEPTH - 2));
      end
`endif
      drive($urandom_range(99) < push_pct, WIDTH'($urandom), $urandom_range(99) < (105 - push_pct));
    end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_fill();
    test_simultaneous();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
